uart_pkt_parser: RTL and testbench
==================================

# uart_pkt_parser

Byte-level framing stage directly downstream of the UART receiver. Consumes the receiver's `data`/`valid` byte stream, hunts for a sync byte, collects a length-prefixed payload into an internal buffer, and optionally checks a checksum. A complete frame is held for the host-side logic to read by address and release with an acknowledge. Malformed, stalled and overrun traffic is reported on single-cycle error pulses.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: maximum payload bytes, range 1..255. Buffer depth equals MAX_LEN.
- `TIMEOUT_CYCLES`, 38400: maximum idle `clk` cycles between bytes inside a frame (1 ms at 38.4 MHz).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `soft_reset` in 1: synchronous abort; highest priority after `rst`.
- `rx_data` in 8: byte from the receiver; stable while `rx_valid` is high.
- `rx_valid` in 1: level-type valid from the receiver. It stays high for an arbitrary time after a byte.
- `frame_valid` out 1: a complete frame is held.
- `frame_len` out 8: payload length of the held frame.
- `rd_addr` in 8: payload read index.
- `rd_data` out 8: combinational `buf[rd_addr]`. Reads 0 when `rd_addr >= frame_len`.
- `frame_ack` in 1: releases the held frame.
- `err_len` out 1: pulse; length byte was 0 or greater than MAX_LEN.
- `err_csum` out 1: pulse; checksum mismatch.
- `err_timeout` out 1: pulse; inter-byte timeout.
- `err_overrun` out 1: pulse; a byte arrived while a frame was held.
- `frame_count` out 16: count of good frames. Wraps modulo 2^16.

## Operation
Byte strobe:
- `rx_valid_q` is `rx_valid` registered.
- `strobe = rx_valid & ~rx_valid_q`.
- Exactly one strobe is generated per received byte, however long `valid` stays high.

State machine:
- IDLE: on strobe with `rx_data == SYNC_BYTE`, go to LEN. Other bytes are discarded silently.
- LEN:
  - If the byte is 0 or greater than MAX_LEN: pulse `err_len` and go to IDLE.
  - Otherwise: latch `len`, clear `idx`, initialise `sum = byte`, and go to PAYLOAD.
- PAYLOAD: on each strobe, `buf[idx] <= byte`, `idx++`, and `sum += byte` (8-bit, wrapping). After the `len`-th byte, go to CSUM (macro on) or HOLD (macro off).
- CSUM:
  - If `(sum + byte) mod 256 == 0`, go to HOLD.
  - Otherwise pulse `err_csum` and go to IDLE.
- HOLD:
  - `frame_valid = 1` and `frame_len = len`.
  - A strobe pulses `err_overrun` and the byte is dropped. The parser does not re-sync.
  - `frame_ack` takes the FSM to IDLE.

Timeout:
- A counter clears on every strobe and on entry to LEN.
- It counts only in LEN, PAYLOAD and CSUM.
- When it reaches TIMEOUT_CYCLES: pulse `err_timeout` and go to IDLE.

Other rules:
- `frame_count` increments on entry to HOLD.
- `soft_reset` forces IDLE, drops `frame_valid`, and suppresses all error pulses that cycle. It does not change `frame_count` or buffer contents.
- `rst` clears everything.

## Timing
Reset values:
- `frame_valid`, `frame_len`, all `err_*` and `frame_count` are 0.
- State is IDLE. `rx_valid_q` is 0.
- Buffer contents are don't-care. `rd_data` reads 0 because `frame_len` is 0.

Latencies:
- A byte is consumed at the clock edge ending its strobe cycle N.
- State and error effects are visible in cycle N+1.
- `frame_valid` rises in cycle N+1 after the final byte's strobe (checksum byte, or last payload byte when the macro is off).
- Each error pulse is exactly 1 cycle, asserted in N+1. A timeout pulse appears in the cycle after the counter hits the limit.
- `frame_ack` sampled high in HOLD makes `frame_valid` low the next cycle. `frame_ack` outside HOLD is ignored.

Boundary cases:
- Strobe in the same cycle as `frame_ack` in HOLD: counted as overrun and dropped.
- Strobe in the same cycle as the timeout hit: timeout wins and the byte is dropped.
- `frame_len` and `rd_data` are stable for the whole HOLD period.

## Configuration
- `UART_PKT_CHECKSUM_EN` defined: CSUM state present; every frame carries a trailing checksum byte; `err_csum` is active.
- Not defined: CSUM state and `sum` logic removed; PAYLOAD goes directly to HOLD; `err_csum` is tied to 0.

## Structure
- `uart_pkt_pkg` holds:
  - the state enum (IDLE, LEN, PAYLOAD, CSUM, HOLD);
  - the default SYNC_BYTE constant;
  - the `clog2`-based index width helper.
- Sub-module `uart_pkt_timeout`:
  - parameter TIMEOUT_CYCLES;
  - inputs `clk`, `rst`, `clear`, `enable`;
  - output `expired`, a 1-cycle pulse.
- Buffer is a flat register array. No RAM macro.

## Test plan
- Sync frame, checksum macro on: A5, 03, 11, 22, 33, checksum = -(0x03+0x11+0x22+0x33) mod 256 = 0x97 → `frame_valid`=1, `frame_len`=3; `rd_addr` 0..2 reads 11/22/33, `rd_addr` 3 reads 0; `frame_count`=1; after `frame_ack`, `frame_valid`=0 next cycle.
- Bad checksum: A5, 02, 10, 20, 00 → `err_csum` high 1 cycle, no `frame_valid`; a following good frame is accepted.
- Length errors: A5, 00 → `err_len`. A5, 0x11 with MAX_LEN=16 → `err_len`; garbage bytes 00/FF before the next A5 are ignored.
- Stall: A5, 04, 01, then silence → `err_timeout` exactly TIMEOUT_CYCLES after the last strobe; FSM returns to IDLE.
- Level valid and overrun: `rx_valid` held high 50 cycles per byte → one byte consumed per byte; a byte sent while HOLD → `err_overrun`, held frame unchanged.
- Mid-frame resets: `soft_reset` during PAYLOAD → IDLE, `frame_count` kept. `rst` during HOLD → all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet framing stage.
package uart_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        HOLD    = 3'd4
    } state_e;

    // Buffer index width; never below one bit so tiny buffers still index cleanly.
    function automatic int idx_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Byte-stream input, frame read port and status pulses of the packet parser.
interface uart_pkt_parser_if;
    logic        soft_reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  rd_addr;
    logic        frame_ack;
    logic        frame_valid;
    logic [7:0]  frame_len;
    logic [7:0]  rd_data;
    logic        err_len;
    logic        err_csum;
    logic        err_timeout;
    logic        err_overrun;
    logic [15:0] frame_count;

    modport slave (
        input  soft_reset, rx_data, rx_valid, rd_addr, frame_ack,
        output frame_valid, frame_len, rd_data,
        output err_len, err_csum, err_timeout, err_overrun, frame_count
    );

    modport master (
        output soft_reset, rx_data, rx_valid, rd_addr, frame_ack,
        input  frame_valid, frame_len, rd_data,
        input  err_len, err_csum, err_timeout, err_overrun, frame_count
    );
endinterface

// File: rtl/uart_pkt_timeout.sv
// Inter-byte idle counter; expired fires once TIMEOUT_CYCLES idle cycles have elapsed.
module uart_pkt_timeout #(
    parameter int TIMEOUT_CYCLES = 38400
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Not gated by clear: a byte landing on the expiry cycle loses to the timeout.
    assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_pkt_parser.sv
// Sync-hunting, length-prefixed frame collector behind the UART receiver.
// Define UART_PKT_CHECKSUM_EN to require and check a trailing checksum byte.
module uart_pkt_parser
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 38400
) (
    input logic              clk,
    input logic              rst,
    uart_pkt_parser_if.slave bus
);
    localparam int IDX_W = idx_width(MAX_LEN);

    state_e      state;
    logic        rx_valid_q;
    logic        strobe;
    logic        expired;
    logic        buf_we;
    logic [7:0]  len;
    logic [7:0]  idx;
    logic [7:0]  frame_len;
    logic [15:0] frame_count;
    logic        err_len;
    logic        err_timeout;
    logic        err_overrun;
    logic [7:0]  buf_mem [MAX_LEN];
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]  sum;
    logic        err_csum;
`endif

    // Level-type valid from the receiver: act only on its rising edge.
    assign strobe = bus.rx_valid && !rx_valid_q;

    uart_pkt_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (strobe || (state == IDLE)),
        .enable ((state == LEN) || (state == PAYLOAD) || (state == CSUM)),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rx_valid_q  <= 1'b0;
            len         <= '0;
            idx         <= '0;
            frame_count <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
            sum         <= '0;
            err_csum    <= 1'b0;
`endif
        end else begin
            rx_valid_q  <= bus.rx_valid;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
            err_csum    <= 1'b0;
`endif
            if (bus.soft_reset) begin
                state <= IDLE;
            end else if (expired) begin
                state       <= IDLE;
                err_timeout <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (strobe && bus.rx_data == SYNC_BYTE) state <= LEN;
                    LEN: if (strobe) begin
                        if (bus.rx_data == 8'd0 || bus.rx_data > 8'(MAX_LEN)) begin
                            err_len <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            len   <= bus.rx_data;
                            idx   <= '0;
`ifdef UART_PKT_CHECKSUM_EN
                            sum   <= bus.rx_data;
`endif
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: if (strobe) begin
                        idx <= idx + 8'd1;
`ifdef UART_PKT_CHECKSUM_EN
                        sum <= sum + bus.rx_data;
                        if (idx == len - 8'd1) state <= CSUM;
`else
                        if (idx == len - 8'd1) begin
                            state       <= HOLD;
                            frame_count <= frame_count + 16'd1;
                        end
`endif
                    end
`ifdef UART_PKT_CHECKSUM_EN
                    CSUM: if (strobe) begin
                        if (8'(sum + bus.rx_data) == 8'd0) begin
                            state       <= HOLD;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            err_csum <= 1'b1;
                            state    <= IDLE;
                        end
                    end
`endif
                    HOLD: begin
                        // Bytes arriving while a frame is held are dropped, not re-parsed.
                        if (strobe) err_overrun <= 1'b1;
                        if (bus.frame_ack) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign buf_we = strobe && !bus.soft_reset && !expired && (state == PAYLOAD);

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[idx[IDX_W-1:0]] <= bus.rx_data;
    end

    assign frame_len       = (state == HOLD) ? len : 8'd0;
    assign bus.frame_valid = (state == HOLD);
    assign bus.frame_len   = frame_len;
    assign bus.rd_data     = (bus.rd_addr < frame_len) ? buf_mem[bus.rd_addr[IDX_W-1:0]] : 8'h00;
    assign bus.frame_count = frame_count;
    assign bus.err_len     = err_len;
    assign bus.err_timeout = err_timeout;
    assign bus.err_overrun = err_overrun;
`ifdef UART_PKT_CHECKSUM_EN
    assign bus.err_csum    = err_csum;
`else
    assign bus.err_csum    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser; frames carry a checksum byte when UART_PKT_CHECKSUM_EN is set.
module tb_uart_pkt_parser;
    localparam int TO = 200;
    localparam int ML = 16;
`ifdef UART_PKT_CHECKSUM_EN
    localparam int EXP_CSUM_ERRS = 1;
`else
    localparam int EXP_CSUM_ERRS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_pkt_parser_if bus();

    uart_pkt_parser #(
        .MAX_LEN(ML),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int n_len = 0, n_csum = 0, n_to = 0, n_ov = 0;
    logic [7:0] pay [ML];

    // Pulse-cycle counters: each error event must add exactly one.
    always @(negedge clk) begin
        if (bus.err_len)     n_len  <= n_len + 1;
        if (bus.err_csum)    n_csum <= n_csum + 1;
        if (bus.err_timeout) n_to   <= n_to + 1;
        if (bus.err_overrun) n_ov   <= n_ov + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk);
        #1 bus.rx_data = b;
        bus.rx_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] len_b, input int n);
        logic [7:0] s;
        s = len_b;
        for (int i = 0; i < n; i++) s = s + pay[i];
        return 8'(8'd0 - s);
    endfunction

    task automatic send_frame(input logic [7:0] len_b, input int n, input int hold);
        send_byte(8'hA5, hold);
        send_byte(len_b, hold);
        for (int i = 0; i < n; i++) send_byte(pay[i], hold);
`ifdef UART_PKT_CHECKSUM_EN
        send_byte(csum_of(len_b, n), hold);
`endif
    endtask

    task automatic ack_frame();
        @(posedge clk);
        #1 bus.frame_ack = 1'b1;
        @(posedge clk);
        #1 bus.frame_ack = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        bus.rd_addr = a;
        #1 chk(tag, bus.rd_data, exp);
    endtask

    initial begin
        bus.soft_reset = 1'b0;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.rd_addr    = 8'h00;
        bus.frame_ack  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.frame_valid, 1'b0);
        chk("rst_len",   bus.frame_len, 8'd0);
        chk("rst_count", bus.frame_count, 16'd0);
        chk("rst_errs",  {bus.err_len, bus.err_csum, bus.err_timeout, bus.err_overrun}, 4'b0);
        chk("rst_rd",    bus.rd_data, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic frame: payload 11 22 33 (checksum 0x97 when enabled).
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'h03, 3, 1);
        @(negedge clk);
        chk("f1_valid", bus.frame_valid, 1'b1);
        chk("f1_len",   bus.frame_len, 8'd3);
        chk("f1_count", bus.frame_count, 16'd1);
        rd(8'd0, 8'h11, "f1_rd0");
        rd(8'd1, 8'h22, "f1_rd1");
        rd(8'd2, 8'h33, "f1_rd2");
        rd(8'd3, 8'h00, "f1_rd3");
        ack_frame();
        @(negedge clk);
        chk("f1_ack", bus.frame_valid, 1'b0);

`ifdef UART_PKT_CHECKSUM_EN
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h10, 1);
        send_byte(8'h20, 1); send_byte(8'h00, 1);
        @(negedge clk);
        chk("csum_bad_valid", bus.frame_valid, 1'b0);
`endif
        pay[0] = 8'h7E;
        send_frame(8'h01, 1, 1);
        @(negedge clk);
        chk("f2_valid", bus.frame_valid, 1'b1);
        chk("f2_count", bus.frame_count, 16'd2);
        rd(8'd0, 8'h7E, "f2_rd0");
        ack_frame();
        chk("csum_errs", n_csum, EXP_CSUM_ERRS);

        // Length 0 and MAX_LEN+1 rejected; garbage ignored before next sync.
        send_byte(8'hA5, 1); send_byte(8'h00, 1);
        send_byte(8'hA5, 1); send_byte(8'h11, 1);
        send_byte(8'h00, 1); send_byte(8'hFF, 1);
        chk("len_errs", n_len, 2);
        pay[0] = 8'hAB; pay[1] = 8'hCD;
        send_frame(8'h02, 2, 1);
        @(negedge clk);
        chk("f3_len",   bus.frame_len, 8'd2);
        chk("f3_count", bus.frame_count, 16'd3);
        rd(8'd0, 8'hAB, "f3_rd0");
        rd(8'd1, 8'hCD, "f3_rd1");
        ack_frame();

        // Full-size frame with rx_valid held 50 cycles per byte, then an overrun.
        for (int i = 0; i < ML; i++) pay[i] = 8'(i * 3 + 1);
        send_frame(8'(ML), ML, 50);
        @(negedge clk);
        chk("f4_valid", bus.frame_valid, 1'b1);
        chk("f4_len",   bus.frame_len, 8'(ML));
        chk("f4_count", bus.frame_count, 16'd4);
        rd(8'd15, 8'h2E, "f4_rd15");
        rd(8'd16, 8'h00, "f4_rd16");
        send_byte(8'h55, 50);
        @(negedge clk);
        chk("ovr_errs",  n_ov, 1);
        chk("ovr_valid", bus.frame_valid, 1'b1);
        chk("ovr_len",   bus.frame_len, 8'(ML));
        rd(8'd15, 8'h2E, "ovr_rd15");
        chk("ovr_count", bus.frame_count, 16'd4);
        ack_frame();

        // Stall after one payload byte: pulse TO cycles after the byte is consumed.
        send_byte(8'hA5, 1); send_byte(8'h04, 1);
        @(posedge clk);
        #1 bus.rx_data = 8'h01;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        chk("to_early", bus.err_timeout, 1'b0);
        @(negedge clk);
        chk("to_hit", bus.err_timeout, 1'b1);
        @(negedge clk);
        chk("to_after", bus.err_timeout, 1'b0);
        chk("to_errs", n_to, 1);

        // Soft reset mid-payload: back to IDLE, count kept, no later timeout.
        send_byte(8'hA5, 1); send_byte(8'h05, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1);
        @(posedge clk);
        #1 bus.soft_reset = 1'b1;
        @(posedge clk);
        #1 bus.soft_reset = 1'b0;
        @(negedge clk);
        chk("srst_valid", bus.frame_valid, 1'b0);
        chk("srst_count", bus.frame_count, 16'd4);
        repeat (TO + 20) @(posedge clk);
        chk("srst_no_to", n_to, 1);
        pay[0] = 8'h42;
        send_frame(8'h01, 1, 1);
        @(negedge clk);
        chk("f5_valid", bus.frame_valid, 1'b1);
        chk("f5_count", bus.frame_count, 16'd5);
        rd(8'd0, 8'h42, "f5_rd0");
        chk("len_errs_final", n_len, 2);

        // Async reset while holding a frame.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.frame_valid, 1'b0);
        chk("arst_len",   bus.frame_len, 8'd0);
        chk("arst_count", bus.frame_count, 16'd0);
        rd(8'd0, 8'h00, "arst_rd0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
